// File: rtl/moving_sum.sv
// Sliding-window sum of the last LENGTH unsigned power samples, valid/ready in and out.
// One-cycle latency, full throughput when the downstream keeps m_ready high.
module moving_sum #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [WIDTH-1:0]                 s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [WIDTH+$clog2(LENGTH)-1:0]  m_data
);

    localparam int OUT_WIDTH = WIDTH + $clog2(LENGTH);
    localparam int PTR_W     = $clog2(LENGTH);
    localparam int FILL_W    = $clog2(LENGTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(LENGTH - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(LENGTH);

    // Delay line is never reset; r_fill says which entries belong to the window.
    logic [WIDTH-1:0]     r_buf [LENGTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [FILL_W-1:0]    r_fill;
    logic [OUT_WIDTH-1:0] r_acc;
    logic                 r_m_valid;

    logic                 w_accept;
    logic [OUT_WIDTH-1:0] w_old;
    logic [OUT_WIDTH-1:0] w_acc_next;

    assign s_ready    = (~r_m_valid | m_ready) & ~clear;
    assign w_accept   = s_valid & s_ready;
    assign w_old      = (r_fill == FULL) ? OUT_WIDTH'(r_buf[r_wptr]) : '0;
    assign w_acc_next = r_acc + OUT_WIDTH'(s_data) - w_old;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_acc     <= '0;
            r_wptr    <= '0;
            r_fill    <= '0;
            r_m_valid <= 1'b0;
        end else if (w_accept) begin
            r_acc     <= w_acc_next;
            r_wptr    <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);
            if (r_fill != FULL) begin
                r_fill <= r_fill + FILL_W'(1);
            end
            r_m_valid <= 1'b1;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Kept free of reset so the delay line can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wptr] <= s_data;
        end
    end

    // The accumulator only moves on an accepted beat, so it doubles as the held output.
    assign m_valid = r_m_valid;
    assign m_data  = r_acc;

endmodule
